ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV32I five-stage pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its operands, immediate, destination and control bits. It computes the ALU result, resolves branches and jumps into a registered redirect, and owns the EX/MEM pipeline register that feeds the memory stage, including stall hold, wrong-path squash and optional operand forwarding.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: MEM-side hold; EX/MEM and redirect state freeze.
- `id_ex_valid` in 1: ID/EX holds a real instruction.
- `id_ex_pc` in 32: instruction PC.
- `id_ex_rs1`, `id_ex_rs2` in 5 each: source register indices.
- `id_ex_rs1_val`, `id_ex_rs2_val` in 32 each: register-file operands.
- `id_ex_imm` in 32: sign-extended immediate.
- `id_ex_rd` in 5: destination index.
- `alu_op` in 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10–15 give 0.
- `alu_src_imm` in 1: operand B = imm, else rs2.
- `is_branch`, `is_jal`, `is_jalr`, `is_lui`, `is_auipc` in 1 each: instruction class.
- `funct3` in 3: branch condition.
- `reg_write`, `mem_read`, `mem_write` in 1 each: control passed to MEM/WB.
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_data` in 32: write-back bus for forwarding.
- `ex_mem_valid` out 1, `ex_mem_result` out 32, `ex_mem_store_data` out 32, `ex_mem_rd` out 5, `ex_mem_reg_write`, `ex_mem_mem_read`, `ex_mem_mem_write` out 1 each: EX/MEM register.
- `redirect_valid` out 1, `redirect_pc` out 32: registered control-flow redirect.

## Operation
- Operand A = rs1 value; B = imm when `alu_src_imm`, else rs2 value. All arithmetic mod 2^32; shifts use B[4:0]; SLT signed, SLTU unsigned.
- Result priority: `is_lui` gives imm; `is_auipc` gives pc+imm; `is_jal`/`is_jalr` give pc+4; otherwise the ALU output.
- Branch condition on the rs1/rs2 values, selected by `funct3`: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
- Target: pc+imm for branch/jal; (rs1+imm) with bit0 cleared for jalr.
- `take` = `id_ex_valid` && !`squash` && (jal || jalr || (branch && cond)).
- `squash` = `redirect_valid` || `squash_pend`. The instruction in ID/EX during a redirect cycle is wrong-path and is captured as a bubble.
- Bubble: `ex_mem_valid`=0 and `reg_write`/`mem_read`/`mem_write`=0. The data fields are don't-care but must be deterministic.
- `ex_mem_store_data` is the forwarded rs2 value.

## Timing
- Reset (async, `reset`=0): all EX/MEM outputs 0, `redirect_valid`=0, `redirect_pc`=0, `squash_pend`=0. Release takes effect on the next rising edge.
- Latency: one cycle, ID/EX to EX/MEM.
- `redirect_valid` is a one-cycle pulse on the edge that captures the resolving instruction into EX/MEM.
- `stall`=1: every register holds, including `redirect_valid` and `redirect_pc`.
  - If `redirect_valid` is high when the stall begins, `squash_pend` is set.
  - `squash_pend` clears on the first non-stalled edge; that edge also bubbles the instruction then in ID/EX.
- Simultaneous `stall`=1 and asynchronous reset: reset wins.
- Back-to-back taken branches: the second is wrong-path and is squashed. No second redirect is issued.

## Configuration
- `EX_FORWARD_EN` defined: per operand, the forwarding priority is:
  1. EX/MEM (`ex_mem_valid && ex_mem_reg_write && ex_mem_rd==rs && rs!=0`, using `ex_mem_result`).
  2. WB (`wb_reg_write && wb_rd==rs && rs!=0`).
  3. The ID/EX value.
  - EX/MEM forwarding of a load (`ex_mem_mem_read`) is not performed; upstream hazard logic stalls for it.
- Not defined: the ID/EX operand values are used unmodified, and the `wb_*` inputs are ignored.

## Test plan
- Reset mid-run: drive `reset`=0 while a branch is resolving -> all outputs 0 immediately; no redirect after release.
- ADDI x5,x0,-1 (imm=0xFFFFFFFF), then SRA with rs1=0x80000000, B=4 -> `ex_mem_result` 0xFFFFFFFF, then 0xF8000000, each one cycle after ID/EX valid.
- BLTU pc=0x100, rs1=1, rs2=0xFFFFFFFF, imm=0x20 -> `redirect_valid` pulse with `redirect_pc`=0x120; the next ID/EX instruction appears as bubble (`ex_mem_valid`=0).
- JALR pc=0x40, rs1=0x203, imm=0 -> `redirect_pc`=0x202, `ex_mem_result`=0x44.
- Branch taken with `stall`=1 for 3 cycles right after resolution -> `redirect_valid` held 4 cycles; the following instruction is squashed once; no duplicate redirect.
- `EX_FORWARD_EN`: ADD x3 writes 7, then ADD x4,x3,x3 with stale rs values 0 -> result 14. With x3 also on WB as 9, EX/MEM wins (14). With rd=x0 there is no forwarding.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : RV32I execute stage: ALU, branch/jump resolution into a
//                registered redirect, and the EX/MEM pipeline register with
//                stall hold and wrong-path squash.
//  Option      : EX_FORWARD_EN enables EX/MEM and WB operand forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        id_ex_valid,
   input  logic [31:0] id_ex_pc,
   input  logic [4:0]  id_ex_rs1,
   input  logic [4:0]  id_ex_rs2,
   input  logic [31:0] id_ex_rs1_val,
   input  logic [31:0] id_ex_rs2_val,
   input  logic [31:0] id_ex_imm,
   input  logic [4:0]  id_ex_rd,
   input  logic [3:0]  alu_op,
   input  logic        alu_src_imm,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        is_lui,
   input  logic        is_auipc,
   input  logic [2:0]  funct3,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        ex_mem_valid,
   output logic [31:0] ex_mem_result,
   output logic [31:0] ex_mem_store_data,
   output logic [4:0]  ex_mem_rd,
   output logic        ex_mem_reg_write,
   output logic        ex_mem_mem_read,
   output logic        ex_mem_mem_write,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam logic [3:0] C_OP_ADD  = 4'd0;
   localparam logic [3:0] C_OP_SUB  = 4'd1;
   localparam logic [3:0] C_OP_SLL  = 4'd2;
   localparam logic [3:0] C_OP_SLT  = 4'd3;
   localparam logic [3:0] C_OP_SLTU = 4'd4;
   localparam logic [3:0] C_OP_XOR  = 4'd5;
   localparam logic [3:0] C_OP_SRL  = 4'd6;
   localparam logic [3:0] C_OP_SRA  = 4'd7;
   localparam logic [3:0] C_OP_OR   = 4'd8;
   localparam logic [3:0] C_OP_AND  = 4'd9;

   localparam logic [2:0] C_F3_BEQ  = 3'b000;
   localparam logic [2:0] C_F3_BNE  = 3'b001;
   localparam logic [2:0] C_F3_BLT  = 3'b100;
   localparam logic [2:0] C_F3_BGE  = 3'b101;
   localparam logic [2:0] C_F3_BLTU = 3'b110;
   localparam logic [2:0] C_F3_BGEU = 3'b111;

   logic        r_squash_pend;
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   logic [31:0] w_op_a;
   logic [31:0] w_op_b;
   logic [4:0]  w_shamt;
   logic [31:0] w_alu;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_imm;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_target;
   logic [31:0] w_result;
   logic        w_cond;
   logic        w_squash;
   logic        w_live;
   logic        w_take;

`ifdef EX_FORWARD_EN
   logic w_ex_hit_a;
   logic w_ex_hit_b;
   logic w_wb_hit_a;
   logic w_wb_hit_b;

   // Loads in EX/MEM carry an address, not data, so they never forward.
   assign w_ex_hit_a = ex_mem_valid && ex_mem_reg_write && !ex_mem_mem_read &&
                       (ex_mem_rd == id_ex_rs1) && (id_ex_rs1 != 5'd0);
   assign w_ex_hit_b = ex_mem_valid && ex_mem_reg_write && !ex_mem_mem_read &&
                       (ex_mem_rd == id_ex_rs2) && (id_ex_rs2 != 5'd0);
   assign w_wb_hit_a = wb_reg_write && (wb_rd == id_ex_rs1) && (id_ex_rs1 != 5'd0);
   assign w_wb_hit_b = wb_reg_write && (wb_rd == id_ex_rs2) && (id_ex_rs2 != 5'd0);

   always_comb begin
      w_rs1_val = id_ex_rs1_val;
      w_rs2_val = id_ex_rs2_val;
      if (w_ex_hit_a)
         w_rs1_val = ex_mem_result;
      else if (w_wb_hit_a)
         w_rs1_val = wb_data;
      if (w_ex_hit_b)
         w_rs2_val = ex_mem_result;
      else if (w_wb_hit_b)
         w_rs2_val = wb_data;
   end
`else
   logic w_unused;

   assign w_rs1_val = id_ex_rs1_val;
   assign w_rs2_val = id_ex_rs2_val;
   assign w_unused  = ^{wb_reg_write, wb_rd, wb_data, id_ex_rs1, id_ex_rs2};
`endif

   assign w_op_a  = w_rs1_val;
   assign w_op_b  = alu_src_imm ? id_ex_imm : w_rs2_val;
   assign w_shamt = w_op_b[4:0];

   always_comb begin
      w_alu = 32'd0;
      case (alu_op)
         C_OP_ADD:  w_alu = w_op_a + w_op_b;
         C_OP_SUB:  w_alu = w_op_a - w_op_b;
         C_OP_SLL:  w_alu = w_op_a << w_shamt;
         C_OP_SLT:  w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
         C_OP_SLTU: w_alu = {31'd0, w_op_a < w_op_b};
         C_OP_XOR:  w_alu = w_op_a ^ w_op_b;
         C_OP_SRL:  w_alu = w_op_a >> w_shamt;
         C_OP_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
         C_OP_OR:   w_alu = w_op_a | w_op_b;
         C_OP_AND:  w_alu = w_op_a & w_op_b;
         default:   w_alu = 32'd0;
      endcase
   end

   // Branch compare always uses the register operands, never the immediate.
   always_comb begin
      w_cond = 1'b0;
      case (funct3)
         C_F3_BEQ:  w_cond = (w_rs1_val == w_rs2_val);
         C_F3_BNE:  w_cond = (w_rs1_val != w_rs2_val);
         C_F3_BLT:  w_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
         C_F3_BGE:  w_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
         C_F3_BLTU: w_cond = (w_rs1_val <  w_rs2_val);
         C_F3_BGEU: w_cond = (w_rs1_val >= w_rs2_val);
         default:   w_cond = 1'b0;
      endcase
   end

   assign w_pc_plus4 = id_ex_pc + 32'd4;
   assign w_pc_imm   = id_ex_pc + id_ex_imm;
   assign w_jalr_sum = w_rs1_val + id_ex_imm;
   assign w_target   = is_jalr ? {w_jalr_sum[31:1], 1'b0} : w_pc_imm;

   always_comb begin
      if (is_lui)
         w_result = id_ex_imm;
      else if (is_auipc)
         w_result = w_pc_imm;
      else if (is_jal || is_jalr)
         w_result = w_pc_plus4;
      else
         w_result = w_alu;
   end

   // The slot behind a redirect (or behind one held over a stall) is wrong-path.
   assign w_squash = redirect_valid || r_squash_pend;
   assign w_live   = id_ex_valid && !w_squash;
   assign w_take   = w_live && (is_jal || is_jalr || (is_branch && w_cond));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_mem_valid      <= 1'b0;
         ex_mem_result     <= 32'd0;
         ex_mem_store_data <= 32'd0;
         ex_mem_rd         <= 5'd0;
         ex_mem_reg_write  <= 1'b0;
         ex_mem_mem_read   <= 1'b0;
         ex_mem_mem_write  <= 1'b0;
         redirect_valid    <= 1'b0;
         redirect_pc       <= 32'd0;
         r_squash_pend     <= 1'b0;
      end else if (stall) begin
         if (redirect_valid)
            r_squash_pend <= 1'b1;
      end else begin
         r_squash_pend    <= 1'b0;
         ex_mem_valid     <= w_live;
         ex_mem_reg_write <= w_live && reg_write;
         ex_mem_mem_read  <= w_live && mem_read;
         ex_mem_mem_write <= w_live && mem_write;
         if (w_live) begin
            ex_mem_result     <= w_result;
            ex_mem_store_data <= w_rs2_val;
            ex_mem_rd         <= id_ex_rd;
         end else begin
            ex_mem_result     <= 32'd0;
            ex_mem_store_data <= 32'd0;
            ex_mem_rd         <= 5'd0;
         end
         redirect_valid <= w_take;
         if (w_take)
            redirect_pc <= w_target;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// Self-checking bench for ex_stage: vector table for single instructions,
// directed sequences for redirect, stall, squash, reset and forwarding.
module tb_ex_stage;

`ifdef EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stall, id_ex_valid;
   logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
   logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [3:0]  alu_op;
   logic        alu_src_imm, is_branch, is_jal, is_jalr, is_lui, is_auipc;
   logic [2:0]  funct3;
   logic        reg_write, mem_read, mem_write;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
   logic [31:0] ex_mem_result, ex_mem_store_data, redirect_pc;
   logic [4:0]  ex_mem_rd;
   logic        redirect_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .id_ex_valid(id_ex_valid),
      .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
      .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val),
      .id_ex_imm(id_ex_imm), .id_ex_rd(id_ex_rd), .alu_op(alu_op),
      .alu_src_imm(alu_src_imm), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc), .funct3(funct3),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result),
      .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
      .ex_mem_mem_write(ex_mem_mem_write), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rd;
      logic [3:0]  op;
      logic        src;
      logic [4:0]  cls;   // {branch, jal, jalr, lui, auipc}
      logic [2:0]  f3;
      logic [2:0]  ctl;   // {reg_write, mem_read, mem_write}
      logic [31:0] exp_res;
      logic        exp_redir;
      logic [31:0] exp_rpc;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [31:0] pc, a, b, imm, input logic [4:0] rd,
                               input logic [3:0] op, input logic src, input logic [4:0] cls,
                               input logic [2:0] f3, input logic [2:0] ctl,
                               input logic [31:0] res, input logic redir,
                               input logic [31:0] rpc);
      vec_t v;
      v.pc = pc; v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.op = op; v.src = src;
      v.cls = cls; v.f3 = f3; v.ctl = ctl; v.exp_res = res; v.exp_redir = redir;
      v.exp_rpc = rpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_ex_valid = 0; id_ex_pc = 0; id_ex_rs1 = 0; id_ex_rs2 = 0;
      id_ex_rs1_val = 0; id_ex_rs2_val = 0; id_ex_imm = 0; id_ex_rd = 0;
      alu_op = 0; alu_src_imm = 0; {is_branch, is_jal, is_jalr, is_lui, is_auipc} = 0;
      funct3 = 0; {reg_write, mem_read, mem_write} = 0;
      wb_reg_write = 0; wb_rd = 0; wb_data = 0;
   endtask

   task automatic drive(input logic [31:0] pc, a, b, imm, input logic [4:0] rs1, rs2, rd,
                        input logic [3:0] op, input logic src, input logic [4:0] cls,
                        input logic [2:0] f3, input logic [2:0] ctl);
      id_ex_valid = 1; id_ex_pc = pc; id_ex_rs1_val = a; id_ex_rs2_val = b;
      id_ex_imm = imm; id_ex_rs1 = rs1; id_ex_rs2 = rs2; id_ex_rd = rd;
      alu_op = op; alu_src_imm = src;
      {is_branch, is_jal, is_jalr, is_lui, is_auipc} = cls;
      funct3 = f3; {reg_write, mem_read, mem_write} = ctl;
   endtask

   task automatic chk_bubble(input string name);
      chk({name, "_valid"}, {31'd0, ex_mem_valid}, 32'd0);
      chk({name, "_ctl"}, {29'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //          pc          a           b           imm         rd op src cls       f3    ctl     res         r  rpc
      vecs[0]  = mk(32'h0,     32'h0,      32'h0,      32'hFFFFFFFF,5, 0, 1, 5'b00000,3'b000,3'b100,32'hFFFFFFFF,0,32'h0);
      vecs[1]  = mk(32'h0,     32'h80000000,32'h0,     32'h4,       6, 7, 1, 5'b00000,3'b000,3'b100,32'hF8000000,0,32'h0);
      vecs[2]  = mk(32'h0,     32'h5,      32'h7,      32'h0,       7, 1, 0, 5'b00000,3'b000,3'b100,32'hFFFFFFFE,0,32'h0);
      vecs[3]  = mk(32'h0,     32'h1,      32'h25,     32'h0,       8, 2, 0, 5'b00000,3'b000,3'b100,32'h00000020,0,32'h0);
      vecs[4]  = mk(32'h0,     32'hFFFFFFFF,32'h1,     32'h0,       9, 3, 0, 5'b00000,3'b000,3'b100,32'h00000001,0,32'h0);
      vecs[5]  = mk(32'h0,     32'hFFFFFFFF,32'h1,     32'h0,       9, 4, 0, 5'b00000,3'b000,3'b100,32'h00000000,0,32'h0);
      vecs[6]  = mk(32'h0,     32'hA5A5A5A5,32'hFFFF0000,32'h0,     10,5, 0, 5'b00000,3'b000,3'b100,32'h5A5AA5A5,0,32'h0);
      vecs[7]  = mk(32'h0,     32'h80000000,32'h4,     32'h0,       11,6, 0, 5'b00000,3'b000,3'b100,32'h08000000,0,32'h0);
      vecs[8]  = mk(32'h0,     32'hF0F00000,32'h0000F0F0,32'h0,     12,8, 0, 5'b00000,3'b000,3'b100,32'hF0F0F0F0,0,32'h0);
      vecs[9]  = mk(32'h0,     32'hFF00FF00,32'h0F0F0F0F,32'h0,     13,9, 0, 5'b00000,3'b000,3'b100,32'h0F000F00,0,32'h0);
      vecs[10] = mk(32'h0,     32'h123,    32'h456,    32'h0,       14,12,0, 5'b00000,3'b000,3'b100,32'h00000000,0,32'h0);
      vecs[11] = mk(32'h0,     32'h1,      32'h2,      32'h12345000,15,0, 1, 5'b00010,3'b000,3'b100,32'h12345000,0,32'h0);
      vecs[12] = mk(32'h1000,  32'h1,      32'h2,      32'h2000,    16,0, 1, 5'b00001,3'b000,3'b100,32'h00003000,0,32'h0);
      vecs[13] = mk(32'h100,   32'h1,      32'hFFFFFFFF,32'h20,     0, 0, 0, 5'b10000,3'b110,3'b000,32'h00000000,1,32'h120);
      vecs[14] = mk(32'h100,   32'h1,      32'h2,      32'h20,      0, 0, 0, 5'b10000,3'b000,3'b000,32'h00000003,0,32'h0);
      vecs[15] = mk(32'h200,   32'h5,      32'hFFFFFFFF,32'hFFFFFFF0,0, 0, 0, 5'b10000,3'b101,3'b000,32'h00000004,1,32'h1F0);
      vecs[16] = mk(32'h200,   32'h7,      32'h7,      32'h8,       0, 0, 0, 5'b10000,3'b010,3'b000,32'h0000000E,0,32'h0);
      vecs[17] = mk(32'h300,   32'h0,      32'h0,      32'h10,      1, 0, 0, 5'b01000,3'b000,3'b100,32'h00000304,1,32'h310);
      vecs[18] = mk(32'h40,    32'h203,    32'h0,      32'h0,       1, 0, 1, 5'b00100,3'b000,3'b100,32'h00000044,1,32'h202);
      vecs[19] = mk(32'h0,     32'h1000,   32'hDEADBEEF,32'h8,      0, 0, 1, 5'b00000,3'b000,3'b001,32'h00001008,0,32'h0);
      vecs[20] = mk(32'h400,   32'h1,      32'hFFFFFFFF,32'h40,     0, 0, 0, 5'b10000,3'b111,3'b000,32'h00000000,0,32'h0);
      vecs[21] = mk(32'h500,   32'h3,      32'h4,      32'h40,      0, 0, 0, 5'b10000,3'b001,3'b000,32'h00000007,1,32'h540);

      // Reset state, with stall asserted to show reset dominates
      idle();
      stall = 1;
      reset = 1;
      #1 reset = 0;
      #1;
      chk("rst_valid", {31'd0, ex_mem_valid}, 32'd0);
      chk("rst_result", ex_mem_result, 32'd0);
      chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      step();
      step();
      reset = 1;
      stall = 0;
      step();
      chk_bubble("post_rst");

      // Single-instruction vectors, each followed by one idle cycle
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].pc, vecs[i].a, vecs[i].b, vecs[i].imm, 5'd1, 5'd2, vecs[i].rd,
               vecs[i].op, vecs[i].src, vecs[i].cls, vecs[i].f3, vecs[i].ctl);
         step();
         chk($sformatf("v%0d_valid", i), {31'd0, ex_mem_valid}, 32'd1);
         chk($sformatf("v%0d_result", i), ex_mem_result, vecs[i].exp_res);
         chk($sformatf("v%0d_rd", i), {27'd0, ex_mem_rd}, {27'd0, vecs[i].rd});
         chk($sformatf("v%0d_ctl", i),
             {29'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, {29'd0, vecs[i].ctl});
         chk($sformatf("v%0d_store", i), ex_mem_store_data, vecs[i].b);
         chk($sformatf("v%0d_redir", i), {31'd0, redirect_valid}, {31'd0, vecs[i].exp_redir});
         if (vecs[i].exp_redir)
            chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].exp_rpc);
         idle();
         step();
         chk_bubble($sformatf("v%0d_gap", i));
         chk($sformatf("v%0d_gap_redir", i), {31'd0, redirect_valid}, 32'd0);
      end

      // ADDI x5,x0,-1 then SRA back-to-back
      drive(32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd5, 4'd0, 1'b1, 5'b0, 3'b0, 3'b100);
      step();
      chk("addi_res", ex_mem_result, 32'hFFFFFFFF);
      drive(32'h4, 32'h80000000, 32'h0, 32'h4, 5'd7, 5'd8, 5'd6, 4'd7, 1'b1, 5'b0, 3'b0, 3'b100);
      step();
      chk("sra_res", ex_mem_result, 32'hF8000000);
      chk("sra_rd", {27'd0, ex_mem_rd}, 32'd6);

      // BLTU taken, following instruction must be a bubble
      drive(32'h100, 32'h1, 32'hFFFFFFFF, 32'h20, 5'd1, 5'd2, 5'd0, 4'd0, 1'b0, 5'b10000, 3'b110, 3'b000);
      step();
      chk("bltu_redir", {31'd0, redirect_valid}, 32'd1);
      chk("bltu_rpc", redirect_pc, 32'h120);
      chk("bltu_valid", {31'd0, ex_mem_valid}, 32'd1);
      drive(32'h104, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd9, 4'd0, 1'b0, 5'b0, 3'b0, 3'b110);
      step();
      chk_bubble("bltu_shadow");
      chk("bltu_pulse_end", {31'd0, redirect_valid}, 32'd0);

      // Taken branch followed by a 3-cycle stall
      idle();
      step();
      drive(32'h800, 32'h9, 32'h9, 32'h10, 5'd1, 5'd2, 5'd0, 4'd0, 1'b0, 5'b10000, 3'b000, 3'b000);
      step();
      chk("stl_redir0", {31'd0, redirect_valid}, 32'd1);
      chk("stl_rpc0", redirect_pc, 32'h810);
      drive(32'h804, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd9, 4'd0, 1'b0, 5'b0, 3'b0, 3'b101);
      stall = 1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("stl_redir%0d", k), {31'd0, redirect_valid}, 32'd1);
         chk($sformatf("stl_rpc%0d", k), redirect_pc, 32'h810);
         chk($sformatf("stl_hold%0d", k), {31'd0, ex_mem_valid}, 32'd1);
         chk($sformatf("stl_hold_ctl%0d", k),
             {29'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 32'd0);
      end
      stall = 0;
      step();
      chk_bubble("stl_squash");
      chk("stl_redir_drop", {31'd0, redirect_valid}, 32'd0);
      step();
      chk("stl_next_valid", {31'd0, ex_mem_valid}, 32'd1);
      chk("stl_next_res", ex_mem_result, 32'd3);
      chk("stl_no_dup", {31'd0, redirect_valid}, 32'd0);

      // Back-to-back taken: JAL then taken BEQ
      drive(32'h900, 32'h0, 32'h0, 32'h100, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 5'b01000, 3'b0, 3'b100);
      step();
      chk("b2b_res", ex_mem_result, 32'h904);
      chk("b2b_rpc", redirect_pc, 32'hA00);
      drive(32'h904, 32'h5, 32'h5, 32'h40, 5'd1, 5'd2, 5'd0, 4'd0, 1'b0, 5'b10000, 3'b000, 3'b000);
      step();
      chk_bubble("b2b_second");
      chk("b2b_redir2", {31'd0, redirect_valid}, 32'd0);
      chk("b2b_rpc2", redirect_pc, 32'hA00);
      idle();
      step();

      // Forwarding (expected values follow the build configuration)
      drive(32'h0, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      chk("fw_x3", ex_mem_result, 32'd7);
      drive(32'h4, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      chk("fw_exmem", ex_mem_result, FWD ? 32'd14 : 32'd0);
      chk("fw_exmem_st", ex_mem_store_data, FWD ? 32'd7 : 32'd0);
      drive(32'h8, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      drive(32'hC, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'd9;
      step();
      chk("fw_prio", ex_mem_result, FWD ? 32'd14 : 32'd0);
      drive(32'h10, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd5, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      chk("fw_wb", ex_mem_result, FWD ? 32'd18 : 32'd0);
      wb_reg_write = 0;
      drive(32'h14, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd0, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      drive(32'h18, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'd9;
      step();
      chk("fw_x0", ex_mem_result, 32'd0);
      wb_reg_write = 0;
      drive(32'h1C, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd7, 4'd0, 1'b1, 5'b0, 3'b0, 3'b110);
      step();
      chk("fw_lw_addr", ex_mem_result, 32'h104);
      drive(32'h20, 32'h5, 32'h0, 32'h0, 5'd7, 5'd0, 5'd8, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      chk("fw_no_load", ex_mem_result, 32'd5);

      // Reset while a branch is resolving
      drive(32'hB00, 32'h1, 32'h2, 32'h40, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 5'b10000, 3'b001, 3'b000);
      step();
      chk("mid_redir_pre", {31'd0, redirect_valid}, 32'd1);
      stall = 1;
      #1 reset = 0;
      #1;
      chk("mid_rst_valid", {31'd0, ex_mem_valid}, 32'd0);
      chk("mid_rst_redir", {31'd0, redirect_valid}, 32'd0);
      chk("mid_rst_rpc", redirect_pc, 32'd0);
      chk("mid_rst_res", ex_mem_result, 32'd0);
      idle();
      step();
      reset = 1;
      stall = 0;
      step();
      chk("mid_rel_redir", {31'd0, redirect_valid}, 32'd0);
      drive(32'h0, 32'h2, 32'h3, 32'h0, 5'd0, 5'd0, 5'd9, 4'd0, 1'b0, 5'b0, 3'b0, 3'b100);
      step();
      chk("mid_rel_live", {31'd0, ex_mem_valid}, 32'd1);
      chk("mid_rel_res", ex_mem_result, 32'd5);
      chk("mid_rel_noredir", {31'd0, redirect_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
